// File: rtl/push_lock_pkg.sv
// Shared types and helpers for the push-button lock blocks.
package push_lock_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        OPEN,
        LOCKOUT
    } state_t;

    // Never returns less than 1, so every derived vector keeps at least one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/push_sync_edge.sv
// Two-flop synchroniser for raw button levels plus a one-cycle rising-edge pulse per bit.
module push_sync_edge #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] rise
);

    logic [W-1:0] s1;
    logic [W-1:0] s2;
    logic [W-1:0] s3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/push_seq_lock.sv
// Sequence lock: programmable button code, inter-press timeout, timed open window
// and a lockout after repeated wrong presses.
module push_seq_lock
    import push_lock_pkg::*;
#(
    parameter int N_BTN       = 14,
    parameter int SEQ_LEN     = 14,
    parameter int TIMEOUT_CYC = 255,
    parameter int OPEN_CYC    = 100,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYC    = 1000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_BTN-1:0]              push,
    input  logic                          code_we,
    input  logic [clog2(SEQ_LEN)-1:0]     code_idx,
    input  logic [clog2(N_BTN)-1:0]       code_val,
    output logic                          unlock,
    output logic                          err,
    output logic                          locked_out,
    output logic [clog2(SEQ_LEN+1)-1:0]   progress
);

    localparam int BW = clog2(N_BTN);
    localparam int PW = clog2(SEQ_LEN + 1);
    localparam int TW = clog2(TIMEOUT_CYC + 1);
    localparam int OW = clog2(OPEN_CYC + 1);
    localparam int FW = clog2(MAX_FAIL + 1);
    localparam int LW = clog2(LOCK_CYC + 1);

    state_t          state;
    logic [TW-1:0]   tmo_cnt;
    logic [OW-1:0]   open_cnt;
    logic [FW-1:0]   fail_cnt;
    logic [LW-1:0]   lock_cnt;
    logic [BW-1:0]   table_q [SEQ_LEN];

    logic [N_BTN-1:0] rise;
    logic             press;
    logic             single;
    logic             match;
    logic             wr_ok;
    logic [BW-1:0]    btn_id;
    logic [BW-1:0]    exp_id;

    push_sync_edge #(.W(N_BTN)) u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (push),
        .rise  (rise)
    );

    // A press with several simultaneous rising bits never matches, whatever btn_id says.
    always_comb begin
        press  = |rise;
        single = press && ((rise & (rise - N_BTN'(1))) == '0);
        btn_id = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (rise[i]) btn_id = BW'(i);
        end
        exp_id = '0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (int'(progress) == i) exp_id = table_q[i];
        end
        match = single && (btn_id == exp_id);
        wr_ok = code_we && (state == IDLE) &&
                (int'(code_idx) < SEQ_LEN) && (int'(code_val) < N_BTN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SEQ_LEN; i++) table_q[i] <= BW'(i % N_BTN);
        end else if (wr_ok) begin
            for (int i = 0; i < SEQ_LEN; i++) begin
                if (int'(code_idx) == i) table_q[i] <= code_val;
            end
        end
    end

    // IDLE and COLLECT share the press handling; progress is always 0 in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            progress   <= '0;
            tmo_cnt    <= '0;
            open_cnt   <= '0;
            fail_cnt   <= '0;
            lock_cnt   <= '0;
            unlock     <= 1'b0;
            err        <= 1'b0;
            locked_out <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE, COLLECT: begin
                    if (press && !match) begin
                        err      <= 1'b1;
                        progress <= '0;
                        fail_cnt <= fail_cnt + FW'(1);
                        if (int'(fail_cnt) + 1 == MAX_FAIL) begin
                            state      <= LOCKOUT;
                            lock_cnt   <= '0;
                            locked_out <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (press) begin
                        tmo_cnt <= '0;
                        if (int'(progress) + 1 == SEQ_LEN) begin
                            state    <= OPEN;
                            progress <= PW'(SEQ_LEN);
                            open_cnt <= '0;
                            fail_cnt <= '0;
                            unlock   <= 1'b1;
                        end else begin
                            state    <= COLLECT;
                            progress <= progress + PW'(1);
                        end
                    end else if (state == COLLECT) begin
                        if (int'(tmo_cnt) == TIMEOUT_CYC - 1) begin
                            err      <= 1'b1;
                            progress <= '0;
                            state    <= IDLE;
                        end else begin
                            tmo_cnt <= tmo_cnt + TW'(1);
                        end
                    end
                end
                OPEN: begin
                    if (press || (int'(open_cnt) == OPEN_CYC - 1)) begin
                        state    <= IDLE;
                        progress <= '0;
                        unlock   <= 1'b0;
                    end else begin
                        open_cnt <= open_cnt + OW'(1);
                    end
                end
                LOCKOUT: begin
                    if (int'(lock_cnt) == LOCK_CYC - 1) begin
                        state      <= IDLE;
                        fail_cnt   <= '0;
                        locked_out <= 1'b0;
                    end else begin
                        lock_cnt <= lock_cnt + LW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_push_seq_lock.sv
// Directed bench for push_seq_lock with the default 14-button, 14-step build.
module tb_push_seq_lock;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] push;
    logic        code_we;
    logic [3:0]  code_idx;
    logic [3:0]  code_val;
    logic        unlock;
    logic        err;
    logic        locked_out;
    logic [3:0]  progress;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    push_seq_lock dut (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .code_we    (code_we),
        .code_idx   (code_idx),
        .code_val   (code_val),
        .unlock     (unlock),
        .err        (err),
        .locked_out (locked_out),
        .progress   (progress)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
            $error("[TB] %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle button pulse; returns just after the edge that acts on it.
    task automatic applyStimulus(input logic [13:0] mask);
        @(negedge clk) push = mask;
        @(negedge clk) push = '0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic enterRange(input int lo, input int hi);
        for (int b = lo; b <= hi; b++) applyStimulus(14'b1 << b);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset   = 1'b0;
        push    = '0;
        code_we = 1'b0;
        @(negedge clk);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic writeTable(input logic [3:0] idx, input logic [3:0] val);
        @(negedge clk);
        code_we  = 1'b1;
        code_idx = idx;
        code_val = val;
        @(negedge clk) code_we = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        push     = '0;
        code_we  = 1'b0;
        code_idx = '0;
        code_val = '0;
        #1 reset = 1'b0;
        waitCycles(3);
        checkOutput("rst_unlock", 32'(unlock), 0);
        checkOutput("rst_err", 32'(err), 0);
        checkOutput("rst_locked", 32'(locked_out), 0);
        checkOutput("rst_progress", 32'(progress), 0);
        @(negedge clk) reset = 1'b1;
        waitCycles(2);

        // Full default code 0..13, then the open window length.
        for (int b = 0; b < 13; b++) begin
            applyStimulus(14'b1 << b);
            checkOutput($sformatf("seq_progress_%0d", b + 1), 32'(progress), 32'(b + 1));
        end
        checkOutput("seq_unlock_before", 32'(unlock), 0);
        applyStimulus(14'b1 << 13);
        checkOutput("open_unlock", 32'(unlock), 1);
        checkOutput("open_progress", 32'(progress), 14);
        waitCycles(99);
        checkOutput("open_last_cycle", 32'(unlock), 1);
        waitCycles(1);
        checkOutput("open_expired", 32'(unlock), 0);
        checkOutput("open_expired_progress", 32'(progress), 0);

        // Three wrong attempts lead to lockout.
        doReset();
        for (int a = 0; a < 2; a++) begin
            enterRange(0, 2);
            checkOutput("wrong_pre_progress", 32'(progress), 3);
            applyStimulus(14'b1 << 5);
            checkOutput("wrong_err", 32'(err), 1);
            checkOutput("wrong_progress", 32'(progress), 0);
            checkOutput("wrong_not_locked", 32'(locked_out), 0);
            waitCycles(1);
            checkOutput("wrong_err_one_cycle", 32'(err), 0);
        end
        enterRange(0, 2);
        applyStimulus(14'b1 << 5);
        checkOutput("lock_err", 32'(err), 1);
        checkOutput("lock_entry", 32'(locked_out), 1);
        applyStimulus(14'b1 << 0);
        checkOutput("lock_press_ignored", 32'(progress), 0);
        checkOutput("lock_still", 32'(locked_out), 1);
        waitCycles(995);
        checkOutput("lock_last_cycle", 32'(locked_out), 1);
        waitCycles(1);
        checkOutput("lock_expired", 32'(locked_out), 0);
        applyStimulus(14'b1 << 0);
        checkOutput("after_lock_press", 32'(progress), 1);

        // Timeouts do not count as failures.
        doReset();
        for (int t = 0; t < 3; t++) begin
            applyStimulus(14'b1 << 0);
            checkOutput("tmo_progress", 32'(progress), 1);
            waitCycles(254);
            checkOutput("tmo_not_yet", 32'(err), 0);
            checkOutput("tmo_hold_progress", 32'(progress), 1);
            waitCycles(1);
            checkOutput("tmo_err", 32'(err), 1);
            checkOutput("tmo_progress_clear", 32'(progress), 0);
        end
        checkOutput("tmo_no_lockout", 32'(locked_out), 0);

        // Two buttons in the same cycle count as one wrong press.
        doReset();
        applyStimulus(14'h0014);
        checkOutput("multi_err", 32'(err), 1);
        checkOutput("multi_progress", 32'(progress), 0);
        applyStimulus(14'b1 << 5);
        checkOutput("multi_second_fail", 32'(locked_out), 0);
        applyStimulus(14'b1 << 5);
        checkOutput("multi_third_fail", 32'(locked_out), 1);

        // Table programming, dropped writes, and a write ignored during COLLECT.
        doReset();
        writeTable(4'd0, 4'd7);
        writeTable(4'd1, 4'd3);
        writeTable(4'd3, 4'd15);
        writeTable(4'd14, 4'd0);
        applyStimulus(14'b1 << 0);
        checkOutput("tbl_old_code_err", 32'(err), 1);
        applyStimulus(14'b1 << 7);
        checkOutput("tbl_step0", 32'(progress), 1);
        writeTable(4'd2, 4'd9);
        applyStimulus(14'b1 << 3);
        checkOutput("tbl_step1", 32'(progress), 2);
        applyStimulus(14'b1 << 2);
        checkOutput("tbl_collect_write_ignored", 32'(progress), 3);
        applyStimulus(14'b1 << 3);
        checkOutput("tbl_bad_val_dropped", 32'(progress), 4);
        enterRange(4, 13);
        checkOutput("tbl_unlock", 32'(unlock), 1);

        // Reset while open aborts at once and restores the default table.
        @(negedge clk) reset = 1'b0;
        #1;
        checkOutput("rst_open_unlock", 32'(unlock), 0);
        checkOutput("rst_open_progress", 32'(progress), 0);
        @(negedge clk) reset = 1'b1;
        waitCycles(1);
        applyStimulus(14'b1 << 0);
        checkOutput("rst_table_default", 32'(progress), 1);
        enterRange(1, 13);
        checkOutput("reopen_unlock", 32'(unlock), 1);
        applyStimulus(14'b1 << 0);
        checkOutput("relock_unlock", 32'(unlock), 0);
        checkOutput("relock_progress", 32'(progress), 0);
        checkOutput("relock_no_err", 32'(err), 0);

        // Reset while locked out.
        applyStimulus(14'b1 << 5);
        applyStimulus(14'b1 << 5);
        applyStimulus(14'b1 << 5);
        checkOutput("lock2_entry", 32'(locked_out), 1);
        @(negedge clk) reset = 1'b0;
        #1;
        checkOutput("rst_lock_cleared", 32'(locked_out), 0);
        @(negedge clk) reset = 1'b1;
        waitCycles(1);
        applyStimulus(14'b1 << 0);
        checkOutput("rst_lock_press_ok", 32'(progress), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
